// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with a registered ready,
// bubble-gated control output, synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                main_vld_q, main_vld_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic                skid_vld_q, skid_vld_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic push, pop;

    assign push = in_valid_i & in_ready_q;
    assign pop  = main_vld_q & out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    main_vld_d  = 1'b1;
                    main_ctrl_d = in_ctrl_i;
                    main_data_d = in_data_i;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (push) begin
                    if (pop) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end else begin
                        skid_vld_d  = 1'b1;
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                        state_d     = FULL;
                    end
                end else if (pop) begin
                    main_vld_d = 1'b0;
                    state_d    = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    skid_vld_d  = 1'b0;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (main_vld_q && !out_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Flush overrides every update above; data fields are left as they are.
        if (flush_i) begin
            state_d     = EMPTY;
            main_vld_d  = 1'b0;
            skid_vld_d  = 1'b0;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            stall_cnt_d = '0;
        end

        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_vld_q  <= main_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_vld_q;
    assign out_ctrl_o  = main_vld_q ? main_ctrl_q : '0;
    assign out_data_o  = main_data_q;
    assign occupancy_o = 2'(state_q);
    assign stall_cnt_o = stall_cnt_q;

endmodule
